// File: rtl/lpn_pkg.sv
// Shared definitions for the LPN error-vector selection blocks: default widths,
// the selector state encoding and the lane-count legality check.
package lpn_pkg;

   localparam int POOL_W_DEF = 450;
   localparam int OUT_W_DEF  = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } sel_state_e;

   function automatic bit lanes_ok(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
   endfunction

endpackage

// File: rtl/bit_sel_lane.sv
// Combinational chunk selector: takes valid bits MSB-first until the remaining
// budget is used up, packing them MSB-aligned and reporting how many were taken.
module bit_sel_lane #(
   parameter int LANES = 4,
   parameter int CNT_W = 9,
   parameter int K_W   = $clog2(LANES + 1)
) (
   input  logic [LANES-1:0] e_c,
   input  logic [LANES-1:0] idx_c,
   input  logic [CNT_W-1:0] remaining,
   output logic [LANES-1:0] acc_bits,
   output logic [K_W-1:0]   acc_k
);

   logic [LANES-1:0] acc_v;
   logic [K_W-1:0]   cnt_v;
   logic             take_v;
   int               slot_v;

   // Running prefix count over the chunk, highest lane first
   always_comb begin
      acc_v  = '0;
      cnt_v  = '0;
      take_v = 1'b0;
      slot_v = 0;
      for (int i = LANES - 1; i >= 0; i--) begin
         take_v        = idx_c[i] && (CNT_W'(cnt_v) < remaining);
         slot_v        = LANES - 1 - int'(cnt_v);
         acc_v[slot_v] = take_v ? e_c[i] : acc_v[slot_v];
         cnt_v         = cnt_v + K_W'(take_v);
      end
   end

   assign acc_bits = acc_v;
   assign acc_k    = cnt_v;

endmodule

// File: rtl/bit_sel_multi.sv
// Multi-lane LPN error-bit selector: scans the candidate pool MSB-first under a
// validity mask, LANES bits per enabled cycle, compacting up to OUT_W bits.
module bit_sel_multi
   import lpn_pkg::*;
#(
   parameter int POOL_W = POOL_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int LANES  = 4,
   parameter int CNT_W  = $clog2(OUT_W + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              en,
   input  logic              start,
   input  logic [CNT_W-1:0]  number_select,
   input  logic [POOL_W-1:0] e_w,
   input  logic [POOL_W-1:0] index_w,
   output logic              busy,
   output logic              done,
   output logic              short,
   output logic [CNT_W-1:0]  sel_count,
   output logic [OUT_W-1:0]  selected_e
);

   localparam int NCHUNK  = (POOL_W + LANES - 1) / LANES;
   localparam int POS_MAX = NCHUNK * LANES;
   localparam int POS_W   = $clog2(POS_MAX + 1);
   localparam int K_W     = $clog2(LANES + 1);

   localparam logic [POS_W-1:0] POS_LIMIT = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0] POS_LAST  = POS_W'(POS_MAX - LANES);
   localparam logic [POS_W-1:0] POS_STEP  = POS_W'(LANES);
   localparam logic [POS_W-1:0] POOL_END  = POS_W'(POOL_W);
   localparam logic [CNT_W-1:0] OUT_MAX   = CNT_W'(OUT_W);

   if (!lanes_ok(LANES)) begin : g_lanes_bad
      $error("bit_sel_multi: LANES must be 1, 2, 4 or 8");
   end

   sel_state_e        state_q, state_d;
   logic [POOL_W-1:0] e_q, e_d;
   logic [POOL_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]  target_q, target_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OUT_W-1:0]  sel_q, sel_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              short_q, short_d;

   logic [CNT_W-1:0]  remaining_s;
   logic [LANES-1:0]  acc_s;
   logic [K_W-1:0]    k_s;
   logic [CNT_W-1:0]  cnt_n_s;
   logic [POS_W-1:0]  pos_n_s;

   assign remaining_s = target_q - cnt_q;

   bit_sel_lane #(
      .LANES (LANES),
      .CNT_W (CNT_W),
      .K_W   (K_W)
   ) u_lane (
      .e_c       (e_q[POOL_W-1 -: LANES]),
      .idx_c     (idx_q[POOL_W-1 -: LANES]),
      .remaining (remaining_s),
      .acc_bits  (acc_s),
      .acc_k     (k_s)
   );

   // Next-state logic: start wins over a scan step; nothing moves while en is low
   always_comb begin
      state_d  = state_q;
      e_d      = e_q;
      idx_d    = idx_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      pos_d    = pos_q;
      busy_d   = busy_q;
      done_d   = done_q;
      short_d  = short_q;
      cnt_n_s  = cnt_q + CNT_W'(k_s);
      pos_n_s  = (pos_q >= POS_LAST) ? POS_LIMIT : (pos_q + POS_STEP);

      if (en) begin
         if (start) begin
            state_d  = SCAN;
            e_d      = e_w;
            idx_d    = index_w;
            target_d = (number_select > OUT_MAX) ? OUT_MAX : number_select;
            cnt_d    = '0;
            sel_d    = '0;
            pos_d    = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            short_d  = 1'b0;
         end else if (state_q == SCAN) begin
            // Accepted bits arrive MSB-aligned; right-justify the top k before inserting
            sel_d = (sel_q << k_s) | (OUT_W'(acc_s) >> (K_W'(LANES) - k_s));
            cnt_d = cnt_n_s;
            e_d   = e_q << LANES;
            idx_d = idx_q << LANES;
            pos_d = pos_n_s;
            if (cnt_n_s == target_q) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               short_d = 1'b0;
            end else if (pos_n_s >= POOL_END) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               short_d = 1'b1;
            end else begin
               state_d = SCAN;
            end
         end else begin
            state_d = state_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, pool, counters and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         e_q      <= '0;
         idx_q    <= '0;
         target_q <= '0;
         cnt_q    <= '0;
         sel_q    <= '0;
         pos_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         short_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         e_q      <= e_d;
         idx_q    <= idx_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         pos_q    <= pos_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         short_q  <= short_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign short      = short_q;
   assign sel_count  = cnt_q;
   assign selected_e = sel_q;

endmodule

// File: tb/tb_bit_sel_multi.sv
// Directed bench for bit_sel_multi: three instances (LANES 1, 4, 8) share the
// same stimulus; latencies and results are checked against hand-derived values.
module tb_bit_sel_multi;

   localparam int PW = 450;
   localparam int OW = 256;
   localparam int CW = 9;

   logic          clk = 1'b0;
   logic          resetn;
   logic          en;
   logic          start;
   logic [CW-1:0] nsel;
   logic [PW-1:0] e_w;
   logic [PW-1:0] idx_w;

   logic          busy [3];
   logic          done [3];
   logic          shrt [3];
   logic [CW-1:0] cnt  [3];
   logic [OW-1:0] sel  [3];

   int checks = 0;
   int errors = 0;
   int lat [3];

   logic [PW-1:0] alt, ones, idx2, e2, idx3;
   logic [OW-1:0] m100, alt40;

   always #5 clk = ~clk;

   bit_sel_multi #(.LANES(1)) u_l1 (
      .clk(clk), .resetn(resetn), .en(en), .start(start), .number_select(nsel),
      .e_w(e_w), .index_w(idx_w), .busy(busy[0]), .done(done[0]), .short(shrt[0]),
      .sel_count(cnt[0]), .selected_e(sel[0]));

   bit_sel_multi #(.LANES(4)) u_l4 (
      .clk(clk), .resetn(resetn), .en(en), .start(start), .number_select(nsel),
      .e_w(e_w), .index_w(idx_w), .busy(busy[1]), .done(done[1]), .short(shrt[1]),
      .sel_count(cnt[1]), .selected_e(sel[1]));

   bit_sel_multi #(.LANES(8)) u_l8 (
      .clk(clk), .resetn(resetn), .en(en), .start(start), .number_select(nsel),
      .e_w(e_w), .index_w(idx_w), .busy(busy[2]), .done(done[2]), .short(shrt[2]),
      .sel_count(cnt[2]), .selected_e(sel[2]));

   task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; the start pulse is consumed by the next edge
   task automatic do_start(input logic [CW-1:0] n, input logic [PW-1:0] e, input logic [PW-1:0] idx);
      nsel  = n;
      e_w   = e;
      idx_w = idx;
      start = 1'b1;
      en    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Steps up to max_c cycles recording when each instance first shows done/short
   task automatic run(input int gate_at, input int gate_len, input int frz, input int max_c);
      lat = '{-1, -1, -1};
      for (int n = 1; n <= max_c; n++) begin
         en = (n > gate_at && n <= gate_at + gate_len) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         if (!en) begin
            chk("gate_freeze_cnt", OW'(cnt[0]), OW'(frz));
            chk("gate_freeze_busy", OW'(busy[0]), OW'(1));
         end
         for (int d = 0; d < 3; d++) begin
            if (lat[d] < 0 && (done[d] || shrt[d])) lat[d] = n;
         end
         if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      end
      en = 1'b1;
   endtask

   task automatic expect_res(input string tag, input int d, input int exp_lat, input bit exp_done,
                             input bit exp_short, input int exp_cnt, input logic [OW-1:0] exp_sel);
      chk({tag, "_lat"}, OW'(lat[d]), OW'(exp_lat));
      chk({tag, "_done"}, OW'(done[d]), OW'(exp_done));
      chk({tag, "_short"}, OW'(shrt[d]), OW'(exp_short));
      chk({tag, "_cnt"}, OW'(cnt[d]), OW'(exp_cnt));
      chk({tag, "_sel"}, sel[d], exp_sel);
   endtask

   initial begin
      resetn = 1'b0;
      en     = 1'b0;
      start  = 1'b0;
      nsel   = '0;
      e_w    = '0;
      idx_w  = '0;
      ones   = '1;
      for (int i = 0; i < PW; i++) alt[i] = (i % 2 == 1);
      idx2 = '0;
      e2   = '0;
      idx2[449] = 1'b1; e2[449] = 1'b1;
      idx2[447] = 1'b1; e2[447] = 1'b0;
      idx2[446] = 1'b1; e2[446] = 1'b1;
      idx2[300] = 1'b1; e2[300] = 1'b1;
      idx3 = '0;
      idx3[99:0] = '1;
      m100 = '0;
      m100[99:0] = '1;
      alt40 = '0;
      alt40[39:0] = 40'hAA_AAAA_AAAA;

      #12;
      for (int d = 0; d < 3; d++) begin
         chk("rst_busy", OW'(busy[d]), OW'(0));
         chk("rst_done", OW'(done[d]), OW'(0));
         chk("rst_short", OW'(shrt[d]), OW'(0));
         chk("rst_cnt", OW'(cnt[d]), OW'(0));
         chk("rst_sel", sel[d], OW'(0));
      end
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Test 1: alternating candidates, everything valid, 8 requested
      do_start(9'd8, alt, ones);
      chk("t1_busy_after_start", OW'(busy[0]), OW'(1));
      chk("t1_done_after_start", OW'(done[0]), OW'(0));
      run(0, 0, 0, 600);
      expect_res("t1_l1", 0, 8, 1'b1, 1'b0, 8, OW'(8'hAA));
      expect_res("t1_l4", 1, 2, 1'b1, 1'b0, 8, OW'(8'hAA));
      expect_res("t1_l8", 2, 1, 1'b1, 1'b0, 8, OW'(8'hAA));

      // Test 2: sparse mask, excess valid bit at 300 never taken
      do_start(9'd3, e2, idx2);
      run(0, 0, 0, 600);
      expect_res("t2_l1", 0, 4, 1'b1, 1'b0, 3, OW'(3'b101));
      expect_res("t2_l4", 1, 1, 1'b1, 1'b0, 3, OW'(3'b101));
      expect_res("t2_l8", 2, 1, 1'b1, 1'b0, 3, OW'(3'b101));

      // Test 3: pool runs out with 100 valid bits against 128 requested
      do_start(9'd128, ones, idx3);
      run(0, 0, 0, 600);
      expect_res("t3_l1", 0, 450, 1'b0, 1'b1, 100, m100);
      expect_res("t3_l4", 1, 113, 1'b0, 1'b1, 100, m100);
      expect_res("t3_l8", 2, 57, 1'b0, 1'b1, 100, m100);

      // Test 4a: request above OUT_W is clamped
      do_start(9'd300, alt, ones);
      run(0, 0, 0, 600);
      expect_res("t4_l1", 0, 256, 1'b1, 1'b0, 256, {128{2'b10}});
      expect_res("t4_l4", 1, 64, 1'b1, 1'b0, 256, {128{2'b10}});
      expect_res("t4_l8", 2, 32, 1'b1, 1'b0, 256, {128{2'b10}});

      // Test 4b: zero request finishes on the first scan cycle
      do_start(9'd0, alt, ones);
      run(0, 0, 0, 600);
      expect_res("t4z_l1", 0, 1, 1'b1, 1'b0, 0, OW'(0));
      expect_res("t4z_l8", 2, 1, 1'b1, 1'b0, 0, OW'(0));

      // Test 5: en low for 5 cycles after two enabled cycles
      do_start(9'd40, alt, ones);
      run(2, 5, 2, 600);
      expect_res("t5_l1", 0, 45, 1'b1, 1'b0, 40, alt40);
      expect_res("t5_l4", 1, 15, 1'b1, 1'b0, 40, alt40);
      expect_res("t5_l8", 2, 10, 1'b1, 1'b0, 40, alt40);

      // Test 6a: restart mid-scan with new operands
      do_start(9'd128, ones, idx3);
      run(0, 0, 0, 10);
      chk("t6_midscan_busy", OW'(busy[0]), OW'(1));
      do_start(9'd3, e2, idx2);
      run(0, 0, 0, 600);
      expect_res("t6_l1", 0, 4, 1'b1, 1'b0, 3, OW'(3'b101));
      expect_res("t6_l4", 1, 1, 1'b1, 1'b0, 3, OW'(3'b101));

      // Test 6b: asynchronous reset between clock edges
      do_start(9'd128, ones, idx3);
      run(0, 0, 0, 5);
      resetn = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("t6_arst_busy", OW'(busy[d]), OW'(0));
         chk("t6_arst_cnt", OW'(cnt[d]), OW'(0));
         chk("t6_arst_sel", sel[d], OW'(0));
      end
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_idle_busy", OW'(busy[0]), OW'(0));
      chk("t6_idle_done", OW'(done[0]), OW'(0));
      chk("t6_idle_short", OW'(shrt[0]), OW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_sel_multi.md
# bit_sel_multi

Parametrised, multi-lane successor to the LPN error-vector bit selector. It scans a POOL_W-bit error candidate vector MSB-first against a same-width validity mask, LANES bits per enabled cycle, and compacts up to OUT_W valid bits into a left-shifting result register. Unlike the single-lane selector, it has explicit IDLE/SCAN/DONE control, a stall input, a restart-anywhere start, an exhaustion flag, and clamping of the request. It sits between the noise/index generator and the LPN syndrome datapath in `system/`.

## Interface
- POOL_W, 450, candidate pool width (bits of e_w and index_w).
- OUT_W, 256, maximum number of selected bits; width of selected_e.
- LANES, 4, pool bits examined per enabled cycle; legal values are 1, 2, 4, 8.
- CNT_W, $clog2(OUT_W+1), width of the count and request fields.

- clk, in, 1, clock.
- resetn, in, 1, reset; asynchronous, active-low.
- en, in, 1, advance enable; when low, state is frozen.
- start, in, 1, single-cycle pulse; loads the operands and begins a scan. Accepted in any state.
- number_select, in, CNT_W, requested bit count; sampled on start.
- e_w, in, POOL_W, candidate error bits; sampled on start.
- index_w, in, POOL_W, validity mask (1 = valid); sampled on start.
- busy, out, 1, high in SCAN.
- done, out, 1, high in DONE when the requested count was reached.
- short, out, 1, high in DONE when the pool ran out before the requested count.
- sel_count, out, CNT_W, number of bits selected so far.
- selected_e, out, OUT_W, compacted result; the earliest selected bit is the most significant of the filled bits.

## Operation
- States:
  - IDLE: reset state.
  - SCAN: entered from any state on start.
  - DONE: entered when the selected count equals the target, or when the scan position reaches POOL_W.
- On start, the block captures the following and moves to SCAN:
  - e_w and index_w into shift registers.
  - target = min(number_select, OUT_W).
  - Clears sel_count, selected_e and the position counter.
- Each SCAN cycle with en=1:
  - Examines the top LANES bits of the pool. In the last chunk, bits beyond POOL_W read as index 0.
  - Computes a per-lane prefix popcount of the valid bits.
  - Accepts valid bits in MSB-first order until sel_count + accepted = target. Excess valid bits in the same chunk are discarded.
  - Shifts selected_e left by the accepted count k (0..LANES) and inserts those bits in order.
  - Adds k to sel_count, shifts both pool registers left by LANES, and adds LANES to the position counter.
- Termination (evaluated on post-update values):
  - sel_count == target → DONE with done=1, short=0.
  - Otherwise, position ≥ POOL_W → DONE with done=0, short=1.
  - When both conditions hold, done wins.
- target == 0: the first SCAN cycle with en=1 goes to DONE with done=1 and selected_e=0.
- en=0: no register changes in any state.
- DONE holds all outputs until the next start or reset.
- A start in SCAN or DONE aborts the current operation and restarts cleanly. No partial result is preserved.
- Width rules:
  - sel_count never exceeds target.
  - The position counter saturates at the ceiling of POOL_W/LANES chunks.

## Timing
- Reset values: state IDLE, busy=0, done=0, short=0, sel_count=0, selected_e=0. Internal registers are also 0.
- Cycle of start: registers are loaded. busy=1 from the next cycle.
- Worst-case latency from start to done or short is ceil(POOL_W/LANES) enabled cycles. This is 113 for the defaults.
- done, short and busy are registered and change on the same edge as the final selected_e update.
- start and en high together: start has priority and no scan step occurs that cycle.
- Asynchronous reset mid-scan returns to IDLE immediately with all outputs zero.

## Structure
- The shared package `lpn_pkg` holds:
  - Default POOL_W/OUT_W constants.
  - The state enum {IDLE, SCAN, DONE}.
  - The LANES legality check.
- Sub-module `bit_sel_lane`:
  - Combinational, LANES bits wide.
  - Inputs: e chunk, index chunk, remaining = target − sel_count.
  - Outputs: packed accepted bits (MSB-aligned) and accept count k.
- Top-level `bit_sel_multi` holds the FSM, the pool shift registers, the counters and the result register.

## Test plan
- Test 1 (LANES=1, defaults): all-ones index, e_w alternating 10…, number_select=8. Expect done after 8 enabled cycles, selected_e[7:0]=8'hAA, sel_count=8.
- Test 2 (LANES=4): index valid only at bits 449, 447, 446, 300 with e=1,0,1,1 there, number_select=3. Expect done after the first chunk, selected_e[2:0]=3'b101. Bit 300 is never taken.
- Test 3 (LANES=8): index has 100 ones, number_select=128. Expect short=1, done=0, sel_count=100, total latency 57 cycles.
- Test 4: number_select=300 (>OUT_W) with an all-ones index. Expect target clamped, sel_count=256, done=1. Separately, number_select=0 gives done=1 after one cycle with selected_e=0.
- Test 5: toggle en low for 5 cycles mid-scan. Expect the result and latency identical to the ungated run plus 5 cycles, with no state change while en=0.
- Test 6: a start pulse mid-scan with new operands gives a clean result for the new operands. resetn pulsed low mid-scan clears all outputs asynchronously and returns to IDLE.
